// File: rtl/road_fighter_pkg.sv
// Shared road geometry, sprite sizes, start coordinates and controller state
// encodings for the multi-rival road fighter game.
package road_fighter_pkg;

    localparam int ROAD_LEFT      = 244;
    localparam int ROAD_RIGHT     = 318;
    localparam int CAR_W          = 14;
    localparam int CAR_H          = 16;
    localparam int PLAYER_START_X = 270;
    localparam int PLAYER_Y       = 300;
    localparam int RIVAL_START_X  = 244;
    localparam int RIVAL_START_Y  = 146;
    localparam int RIVAL_EXIT_Y   = 374;
    localparam int RIVAL_X_SPAN   = 61;
    localparam int SCORE_MAX      = 16383;

    typedef enum logic [2:0] {
        ST_START     = 3'd0,
        ST_IDLE      = 3'd1,
        ST_LEFT_CAR  = 3'd2,
        ST_RIGHT_CAR = 3'd3,
        ST_CRASH     = 3'd4,
        ST_GAME_OVER = 3'd5
    } car_state_t;

    // Two CAR_W x CAR_H boxes given by top-left corners; 11-bit math avoids wrap.
    function automatic logic boxes_overlap(input logic [9:0] ax, input logic [9:0] ay,
                                           input logic [9:0] bx, input logic [9:0] by);
        logic [10:0] ax_w, ay_w, bx_w, by_w;
        ax_w = {1'b0, ax};
        ay_w = {1'b0, ay};
        bx_w = {1'b0, bx};
        by_w = {1'b0, by};
        return (ax_w < bx_w + 11'(CAR_W)) && (bx_w < ax_w + 11'(CAR_W)) &&
               (ay_w < by_w + 11'(CAR_H)) && (by_w < ay_w + 11'(CAR_H));
    endfunction

endpackage

// File: rtl/rival_slot.sv
// One rival car slot: holds position and valid bit, descends on rival ticks,
// retires at the bottom of the road and accepts a spawn while idle.
module rival_slot
    import road_fighter_pkg::*;
#(
    parameter int RIVAL_STEP = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_en,
    input  logic       clear_all,
    input  logic       spawn,
    input  logic [9:0] spawn_x,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic       retire
);

    assign retire = tick_en && active && (y >= 10'(RIVAL_EXIT_Y));

    // A slot that retires this tick is still active, so it cannot be re-spawned
    // until the following tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            x      <= 10'(RIVAL_START_X);
            y      <= 10'(RIVAL_START_Y);
        end else if (clear_all) begin
            active <= 1'b0;
        end else if (tick_en) begin
            if (active) begin
                if (retire) begin
                    active <= 1'b0;
                end else begin
                    y <= y + 10'(RIVAL_STEP);
                end
            end else if (spawn) begin
                active <= 1'b1;
                x      <= spawn_x;
                y      <= 10'(RIVAL_START_Y);
            end
        end
    end

endmodule

// File: rtl/multi_rival_car_ctrl.sv
// Player car controller with several rival car slots: movement FSM, collision
// detection, lives, crash freeze, rival spawning and scoring.
module multi_rival_car_ctrl
    import road_fighter_pkg::*;
#(
    parameter int NUM_RIVALS  = 3,
    parameter int MOVE_DIV    = 4000000,
    parameter int RIVAL_DIV   = 1000000,
    parameter int RIVAL_STEP  = 2,
    parameter int SPAWN_GAP   = 24,
    parameter int START_LIVES = 3,
    parameter int CRASH_TICKS = 50
) (
    input  logic                    clk,
    input  logic                    BTNC,
    input  logic                    BTNL,
    input  logic                    BTNR,
    input  logic [7:0]              random_num,
    output logic [9:0]              car_x_reg,
    output logic [9:0]              car_y_reg,
    output logic [10*NUM_RIVALS-1:0] rival_x_bus,
    output logic [10*NUM_RIVALS-1:0] rival_y_bus,
    output logic [NUM_RIVALS-1:0]   rival_active,
    output logic [2:0]              current_state_out,
    output logic [2:0]              lives,
    output logic [13:0]             score,
    output logic                    game_over
);

    localparam int MW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam int RW = (RIVAL_DIV > 1) ? $clog2(RIVAL_DIV) : 1;
    localparam int CW = $clog2(CRASH_TICKS + 1);
    localparam int SW = $clog2(SPAWN_GAP + 1);

    car_state_t state, state_next;

    logic [MW-1:0]         move_cnt;
    logic [RW-1:0]         rival_cnt;
    logic [CW-1:0]         crash_cnt;
    logic [SW-1:0]         spawn_cnt;
    logic                  player_tick, rival_tick;
    logic                  playing, hit, crash_event, crash_done, rival_en;
    logic                  any_free, spawn_go;
    logic [NUM_RIVALS-1:0] spawn_sel, retire;
    logic [2:0]            retire_cnt;
    logic [14:0]           score_sum;
    logic [7:0]            rn_mod;
    logic [9:0]            spawn_x;

    assign car_y_reg         = 10'(PLAYER_Y);
    assign current_state_out = state;
    assign game_over         = (state == ST_GAME_OVER);

    assign player_tick = (move_cnt == MW'(MOVE_DIV - 1));
    assign rival_tick  = (rival_cnt == RW'(RIVAL_DIV - 1));

    always_ff @(posedge clk) begin
        if (BTNC) begin
            move_cnt  <= '0;
            rival_cnt <= '0;
        end else begin
            move_cnt  <= player_tick ? '0 : move_cnt + MW'(1);
            rival_cnt <= rival_tick ? '0 : rival_cnt + RW'(1);
        end
    end

    // Collision is evaluated on registered positions only.
    always_comb begin
        hit = ({1'b0, car_x_reg} < 11'(ROAD_LEFT)) ||
              ({1'b0, car_x_reg} + 11'(CAR_W) > 11'(ROAD_RIGHT));
        for (int i = 0; i < NUM_RIVALS; i++) begin
            if (rival_active[i] &&
                boxes_overlap(car_x_reg, car_y_reg, rival_x_bus[10*i +: 10], rival_y_bus[10*i +: 10]))
                hit = 1'b1;
        end
    end

    assign playing     = (state == ST_IDLE) || (state == ST_LEFT_CAR) || (state == ST_RIGHT_CAR);
    assign crash_event = playing && hit;
    assign crash_done  = (state == ST_CRASH) && player_tick && (crash_cnt == CW'(CRASH_TICKS - 1));
    assign rival_en    = rival_tick && !crash_event && (playing || state == ST_START);

    always_comb begin
        state_next = state;
        if (crash_event) begin
            state_next = (lives == 3'd1) ? ST_GAME_OVER : ST_CRASH;
        end else begin
            case (state)
                ST_START:     state_next = ST_IDLE;
                ST_IDLE: begin
                    if (BTNR)      state_next = ST_RIGHT_CAR;
                    else if (BTNL) state_next = ST_LEFT_CAR;
                end
                ST_LEFT_CAR:  if (!BTNL) state_next = ST_IDLE;
                ST_RIGHT_CAR: if (!BTNR) state_next = ST_IDLE;
                ST_CRASH:     if (crash_done) state_next = ST_IDLE;
                ST_GAME_OVER: state_next = ST_GAME_OVER;
                default:      state_next = ST_START;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (BTNC) begin
            state     <= ST_START;
            car_x_reg <= 10'(PLAYER_START_X);
            lives     <= 3'(START_LIVES);
            crash_cnt <= '0;
        end else begin
            state <= state_next;
            if (crash_event)
                lives <= lives - 3'd1;
            if (crash_done)
                car_x_reg <= 10'(PLAYER_START_X);
            else if (player_tick && !crash_event && state == ST_LEFT_CAR)
                car_x_reg <= car_x_reg - 10'd1;
            else if (player_tick && !crash_event && state == ST_RIGHT_CAR)
                car_x_reg <= car_x_reg + 10'd1;
            if (state != ST_CRASH)
                crash_cnt <= '0;
            else if (player_tick)
                crash_cnt <= crash_cnt + CW'(1);
        end
    end

    // Spawn decisions use the valid bits from the start of the tick.
    always_comb begin
        spawn_sel = '0;
        any_free  = 1'b0;
        for (int i = 0; i < NUM_RIVALS; i++) begin
            if (!rival_active[i] && !any_free) begin
                spawn_sel[i] = 1'b1;
                any_free     = 1'b1;
            end
        end
    end

    assign spawn_go = rival_en && (spawn_cnt >= SW'(SPAWN_GAP));
    assign rn_mod   = random_num % 8'(RIVAL_X_SPAN);
    assign spawn_x  = 10'(ROAD_LEFT) + {2'b00, rn_mod};

    // The spawning tick counts as the first tick of the next gap; when every
    // slot is busy the counter parks at SPAWN_GAP.
    always_ff @(posedge clk) begin
        if (BTNC) begin
            spawn_cnt <= SW'(SPAWN_GAP);
        end else if (rival_en) begin
            if (spawn_cnt >= SW'(SPAWN_GAP)) begin
                if (any_free)
                    spawn_cnt <= SW'(1);
            end else begin
                spawn_cnt <= spawn_cnt + SW'(1);
            end
        end
    end

    always_comb begin
        retire_cnt = '0;
        for (int i = 0; i < NUM_RIVALS; i++)
            retire_cnt = retire_cnt + 3'(retire[i]);
    end

    assign score_sum = {1'b0, score} + 15'(retire_cnt);

    always_ff @(posedge clk) begin
        if (BTNC)
            score <= '0;
        else if (score_sum > 15'(SCORE_MAX))
            score <= 14'(SCORE_MAX);
        else
            score <= score_sum[13:0];
    end

    for (genvar i = 0; i < NUM_RIVALS; i++) begin : g_slot
        rival_slot #(
            .RIVAL_STEP(RIVAL_STEP)
        ) u_slot (
            .clk      (clk),
            .rst      (BTNC),
            .tick_en  (rival_en),
            .clear_all(crash_done),
            .spawn    (spawn_go && spawn_sel[i]),
            .spawn_x  (spawn_x),
            .x        (rival_x_bus[10*i +: 10]),
            .y        (rival_y_bus[10*i +: 10]),
            .active   (rival_active[i]),
            .retire   (retire[i])
        );
    end

endmodule
